// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the video RAM arbiter.
//   owner_e     - which requester a RAM slot belongs to (routes mem_rdata)
//   cpu_state_e - CPU handshake FSM states
package vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU
  } owner_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD1,
    ST_RD2,
    ST_DONE,
    ST_HOLD
  } cpu_state_e;

endpackage

// File: rtl/vram_post_buf.sv
// vram_post_buf: one-entry posted-write buffer with address compare.
// Only instantiated when VRAM_WRITE_POST_EN is defined.
// Ports:
//   clk, reset            - clock, synchronous active-high reset (empties buffer)
//   load/load_addr/data   - capture a CPU write (only while empty)
//   drain                 - the buffered write was issued to RAM this edge
//   cmp_addr              - address compared against the buffered entry
//   full, buf_addr/data   - buffer contents
//   hit                   - buffer holds a write to cmp_addr
module vram_post_buf
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              full,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic              hit
);

  always_ff @(posedge clk) begin
    if (reset) begin
      full     <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else if (load) begin
      full     <= 1'b1;
      buf_addr <= load_addr;
      buf_data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  assign hit = full && (buf_addr == cmp_addr);

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous video RAM between the VGA fetch port
// (absolute priority, fixed 3-cycle latency) and a CPU read/write port with
// a ready handshake.
// Optional feature: define VRAM_WRITE_POST_EN for a one-entry posted-write
// buffer with read forwarding.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   vid_req, vid_address         - one-cycle fetch strobe and address
//   vid_data                     - fetched byte, held until next fetch
//   cpu_cs, cpu_we, cpu_address,
//   cpu_din                      - CPU request (held until cpu_ready)
//   cpu_dout, cpu_ready          - read data (held), completion pulse
//   mem_addr, mem_we, mem_wdata  - registered RAM slot
//   mem_rdata                    - RAM read data, one cycle after address
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_address,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  cpu_state_e        state;
  owner_e            owner0, owner1;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_din;
  logic              cpu_issue;
  logic              cpu_slot;

`ifdef VRAM_WRITE_POST_EN
  logic              buf_full, buf_hit, buf_load, buf_drain, fwd_hit, fwd;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data, fwd_data;

  vram_post_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_post_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (buf_load),
    .load_addr (cpu_address),
    .load_data (cpu_din),
    .drain     (buf_drain),
    .cmp_addr  (lat_addr),
    .full      (buf_full),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .hit       (buf_hit)
  );

  // A read that hits the buffer completes from the buffer and needs no slot;
  // anything else has to wait until the buffered write is in RAM.
  assign fwd_hit   = !lat_we && buf_hit;
  assign cpu_issue = (state == ST_WAIT) && !vid_req && (!buf_full || fwd_hit);
  assign cpu_slot  = cpu_issue && !fwd_hit;
  assign buf_load  = (state == ST_IDLE) && cpu_cs && cpu_we && !buf_full;
  assign buf_drain = buf_full && !vid_req;
`else
  assign cpu_issue = (state == ST_WAIT) && !vid_req;
  assign cpu_slot  = cpu_issue;
`endif

  // Slot issue and read-data routing
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      owner0    <= OWN_NONE;
      owner1    <= OWN_NONE;
      vid_data  <= '0;
    end else begin
      owner1 <= owner0;
      if (owner1 == OWN_VID) vid_data <= mem_rdata;
      mem_we <= 1'b0;
      owner0 <= OWN_NONE;
      if (vid_req) begin
        mem_addr <= vid_address;
        owner0   <= OWN_VID;
      end else if (cpu_slot) begin
        mem_addr <= lat_addr;
        mem_we   <= lat_we;
        if (lat_we) mem_wdata <= lat_din;
        owner0   <= OWN_CPU;
`ifdef VRAM_WRITE_POST_EN
      end else if (buf_drain) begin
        mem_addr  <= buf_addr;
        mem_we    <= 1'b1;
        mem_wdata <= buf_data;
        owner0    <= OWN_CPU;
`endif
      end
    end
  end

  // CPU handshake FSM. Writes pass through RD2 so cpu_ready follows the
  // cycle in which the write is presented to the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cpu_ready <= 1'b0;
      cpu_dout  <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_din   <= '0;
`ifdef VRAM_WRITE_POST_EN
      fwd       <= 1'b0;
      fwd_data  <= '0;
`endif
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_cs) begin
            lat_addr <= cpu_address;
            lat_we   <= cpu_we;
            lat_din  <= cpu_din;
`ifdef VRAM_WRITE_POST_EN
            fwd      <= 1'b0;
            state    <= buf_load ? ST_RD2 : ST_WAIT;
`else
            state    <= ST_WAIT;
`endif
          end
        end
        ST_WAIT: begin
          if (cpu_issue) begin
            state <= lat_we ? ST_RD2 : ST_RD1;
`ifdef VRAM_WRITE_POST_EN
            fwd      <= fwd_hit;
            fwd_data <= buf_data;
`endif
          end
        end
        ST_RD1: state <= ST_RD2;
        ST_RD2: begin
          if (!lat_we) begin
`ifdef VRAM_WRITE_POST_EN
            cpu_dout <= fwd ? fwd_data : mem_rdata;
`else
            cpu_dout <= mem_rdata;
`endif
          end
          cpu_ready <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: state <= ST_HOLD;
        ST_HOLD: if (!cpu_cs) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
